// File: rtl/cache_pkg.sv
// Shared types for the set-associative write-back cache controller:
// datapath mode encoding, controller FSM states and the way-index width helper.
package cache_pkg;

  typedef enum logic [1:0] {
    CS_IDLE,
    CS_WRITE,
    CS_WRITE_BACK,
    CS_FILL
  } ctrl_state_t;

  typedef enum logic [1:0] {
    ST_CHECK,
    ST_WRITE_BACK,
    ST_FILL
  } cache_fsm_t;

  // A direct-mapped cache still needs a one-bit way select.
  function automatic int way_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Victim way selection: lowest-index invalid way first, otherwise the per-set
// round-robin pointer, which advances only when a pointer-chosen victim is filled.
module cache_victim_sel
  import cache_pkg::*;
#(
  parameter int NUM_WAYS = 2,
  parameter int NUM_SETS = 16,
  localparam int WAY_W = way_bits(NUM_WAYS),
  localparam int IDX_W = $clog2(NUM_SETS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_W-1:0]    index_i,
  input  logic [NUM_WAYS-1:0] way_valid_i,
  input  logic                adv_i,
  input  logic [IDX_W-1:0]    adv_index_i,
  output logic [WAY_W-1:0]    victim_o,
  output logic                from_ptr_o
);

  logic [WAY_W-1:0] inv_way;
  logic             any_inv;

  always_comb begin
    inv_way = '0;
    any_inv = 1'b0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!way_valid_i[w]) begin
        inv_way = WAY_W'(w);
        any_inv = 1'b1;
      end
    end
  end

  if (NUM_WAYS > 1) begin : g_rr
    // Power-of-two way count, so the natural WAY_W-bit overflow is the wrap.
    logic [WAY_W-1:0] rr_q [NUM_SETS];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s < NUM_SETS; s++) rr_q[s] <= '0;
      end else if (adv_i) begin
        rr_q[adv_index_i] <= rr_q[adv_index_i] + WAY_W'(1);
      end
    end

    assign victim_o   = any_inv ? inv_way : rr_q[index_i];
    assign from_ptr_o = !any_inv;
  end else begin : g_dm
    assign victim_o   = '0;
    assign from_ptr_o = 1'b0;
  end

endmodule

// File: rtl/cache_ctrl_wb_assoc.sv
// N-way set-associative write-back/write-allocate L1 cache controller FSM.
// Optional macro CACHE_CTRL_STATS_EN adds saturating hit/miss/write-back counters.
module cache_ctrl_wb_assoc
  import cache_pkg::*;
#(
  parameter int NUM_WAYS = 2,
  parameter int NUM_SETS = 16,
  localparam int WAY_W = way_bits(NUM_WAYS),
  localparam int IDX_W = $clog2(NUM_SETS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cache_read,
  input  logic                cache_write,
  input  logic [IDX_W-1:0]    cache_index,
  output logic                cache_valid,
  output logic                mem_read,
  output logic                mem_write,
  input  logic                mem_valid,
  input  logic [NUM_WAYS-1:0] way_hit,
  input  logic [NUM_WAYS-1:0] way_valid,
  input  logic [NUM_WAYS-1:0] way_dirty,
  output logic [WAY_W-1:0]    ctrl_way,
  output logic                ctrl_tag_ld,
  output logic                ctrl_valid_ld,
  output logic                ctrl_dirty_ld,
  output logic                ctrl_dirty_in,
  output ctrl_state_t         ctrl_state,
  output cache_fsm_t          fsm_state
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [31:0]         stat_hits,
  output logic [31:0]         stat_misses,
  output logic [31:0]         stat_writebacks
`endif
);

  // Handshakes: the CPU holds cache_read/cache_write until the cycle cache_valid
  // is high; memory holds mem_read/mem_write until mem_valid, and each mem_valid
  // cycle completes exactly one transfer of the current state.
  cache_fsm_t       state_q;
  logic [WAY_W-1:0] victim_q, hit_way, victim;
  logic [IDX_W-1:0] index_q;
  logic             from_ptr_q, from_ptr, req, hit, victim_dirty, rr_adv;

  assign req          = cache_read | cache_write;
  assign hit          = |way_hit;
  assign victim_dirty = way_valid[victim] & way_dirty[victim];
  assign rr_adv       = (state_q == ST_FILL) && mem_valid && from_ptr_q;
  assign fsm_state    = state_q;

  always_comb begin
    hit_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (way_hit[w]) hit_way = WAY_W'(w);
    end
  end

  cache_victim_sel #(.NUM_WAYS(NUM_WAYS), .NUM_SETS(NUM_SETS)) u_victim (
    .clk        (clk),
    .rst        (rst),
    .index_i    (cache_index),
    .way_valid_i(way_valid),
    .adv_i      (rr_adv),
    .adv_index_i(index_q),
    .victim_o   (victim),
    .from_ptr_o (from_ptr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_CHECK;
      victim_q   <= '0;
      index_q    <= '0;
      from_ptr_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CHECK: begin
          if (req && !hit) begin
            victim_q   <= victim;
            index_q    <= cache_index;
            from_ptr_q <= from_ptr;
            state_q    <= victim_dirty ? ST_WRITE_BACK : ST_FILL;
          end
        end
        ST_WRITE_BACK: if (mem_valid) state_q <= ST_FILL;
        ST_FILL:       if (mem_valid) state_q <= ST_CHECK;
        default:       state_q <= ST_CHECK;
      endcase
    end
  end

  always_comb begin
    cache_valid   = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ctrl_way      = '0;
    ctrl_tag_ld   = 1'b0;
    ctrl_valid_ld = 1'b0;
    ctrl_dirty_ld = 1'b0;
    ctrl_dirty_in = 1'b0;
    ctrl_state    = CS_IDLE;
    case (state_q)
      ST_CHECK: begin
        if (req && hit) begin
          cache_valid = 1'b1;
          ctrl_way    = hit_way;
          if (cache_write) begin
            ctrl_dirty_ld = 1'b1;
            ctrl_dirty_in = 1'b1;
            ctrl_state    = CS_WRITE;
          end
        end
      end
      ST_WRITE_BACK: begin
        mem_write     = 1'b1;
        ctrl_way      = victim_q;
        ctrl_state    = CS_WRITE_BACK;
        ctrl_dirty_ld = mem_valid;
      end
      ST_FILL: begin
        mem_read      = 1'b1;
        ctrl_way      = victim_q;
        ctrl_state    = CS_FILL;
        ctrl_tag_ld   = mem_valid;
        ctrl_valid_ld = mem_valid;
        ctrl_dirty_ld = mem_valid;
      end
      default: ;
    endcase
  end

  // Tag uniqueness within a set makes more than one hit bit a datapath bug.
  assert property (@(posedge clk) disable iff (rst)
    ((state_q == ST_CHECK) && req) |-> $onehot0(way_hit));

`ifdef CACHE_CTRL_STATS_EN
  logic [31:0] hits_q, misses_q, wbs_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hits_q   <= '0;
      misses_q <= '0;
      wbs_q    <= '0;
    end else begin
      if (cache_valid && (hits_q != '1)) hits_q <= hits_q + 32'd1;
      if ((state_q == ST_CHECK) && req && !hit && (misses_q != '1)) misses_q <= misses_q + 32'd1;
      if ((state_q == ST_WRITE_BACK) && mem_valid && (wbs_q != '1)) wbs_q <= wbs_q + 32'd1;
    end
  end

  assign stat_hits       = hits_q;
  assign stat_misses     = misses_q;
  assign stat_writebacks = wbs_q;
`endif

endmodule
